wb_cmd_master: RTL and testbench

- Wishbone B3 bus initiator, driven by a simple command/data handshake. It is the master-side counterpart to the bus slaves (memory emulator, UART, PWM, SW_LED).
- Occupies one master slot on the intercon. Used by debug and loader logic to issue single and incrementing-burst reads and writes without the CPU.
- Handles ack, err and rty terminations. Includes a bus watchdog.

---
 rtl/wb_cmd_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone B3 initiator driven by a command/write-data handshake, with single and incrementing-burst support.
// Define WB_CMD_MASTER_TIMEOUT_EN to add the per-beat bus watchdog (status 11).
module wb_cmd_master #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned RTY_LIMIT = 15,
    parameter int unsigned RTY_GAP   = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk_int,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [2:0]    cmd_len,
    input  logic [3:0]    cmd_sel,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          rsp_valid,
    output logic [1:0]    rsp_status,
    output logic          busy,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_BUS   = 3'd2;
    localparam logic [2:0] S_RGAP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned RCW = $clog2(RTY_LIMIT + 2);
    localparam int unsigned GCW = (RTY_GAP > 1) ? $clog2(RTY_GAP) : 1;

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [2:0]     len_q, len_d, beat_q, beat_d;
    logic           we_q, we_d;
    logic [3:0]     sel_q, sel_d;
    logic [RCW-1:0] rty_q, rty_d, rty_inc_c;
    logic [GCW-1:0] gap_q, gap_d;
    logic [DW-1:0]  dat_q, dat_d, rd_data_q, rd_data_d;
    logic           cyc_q, cyc_d, stb_q, stb_d;
    logic [2:0]     cti_q, cti_d;
    logic [1:0]     status_q, status_d;
    logic           cmd_ready_q, wr_ready_q, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic           rsp_valid_q, busy_q;
    logic           last_beat_c;
    logic           unused_c;

    assign last_beat_c = (beat_q == len_q);
    assign rty_inc_c   = rty_q + RCW'(1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       term_c;

    assign term_c = wb_ack_i | wb_err_i | wb_rty_i;
    // Counts unterminated BUS cycles; any non-BUS cycle or termination restarts it.
    assign wdog_d = (state_q == S_BUS && !term_c) ? wdog_q + 8'd1 : 8'd0;

    always_ff @(posedge clk_int or posedge rst) begin
        if (rst) wdog_q <= 8'd0;
        else     wdog_q <= wdog_d;
    end
    assign unused_c = ^cmd_adr[1:0];
`else
    assign unused_c = ^{cmd_adr[1:0], 8'(TIMEOUT)};
`endif

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        len_d      = len_q;
        we_d       = we_q;
        sel_d      = sel_q;
        beat_d     = beat_q;
        rty_d      = rty_q;
        gap_d      = gap_q;
        dat_d      = dat_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        status_d   = status_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    adr_d  = {cmd_adr[AW-1:2], 2'b00};
                    len_d  = cmd_len;
                    we_d   = cmd_we;
                    sel_d  = cmd_sel;
                    beat_d = 3'd0;
                    rty_d  = '0;
                    if (cmd_we) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end
            S_WDATA: begin
                stb_d = 1'b0;
                if (wr_valid) begin
                    dat_d   = wr_data;
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    status_d = 2'b01;
                    state_d  = S_DONE;
                end else if (wb_ack_i) begin
                    rty_d = '0;
                    if (!we_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = wb_dat_i;
                        rd_last_d  = last_beat_c;
                    end
                    if (last_beat_c) begin
                        cyc_d    = 1'b0;
                        stb_d    = 1'b0;
                        status_d = 2'b00;
                        state_d  = S_DONE;
                    end else begin
                        adr_d  = adr_q + AW'(4);
                        beat_d = beat_q + 3'd1;
                        if (we_q) begin
                            stb_d   = 1'b0;
                            state_d = S_WDATA;
                        end
                    end
                end else if (wb_rty_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    rty_d = rty_inc_c;
                    if (rty_inc_c > RCW'(RTY_LIMIT)) begin
                        status_d = 2'b10;
                        state_d  = S_DONE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_RGAP;
                    end
                end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                else if (wdog_d == 8'(TIMEOUT)) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    status_d = 2'b11;
                    state_d  = S_DONE;
                end
`endif
            end
            S_RGAP: begin
                if (gap_q == GCW'(RTY_GAP - 1)) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Cycle type follows the beat about to be presented, so a retried beat gets it fresh.
        if (state_d != S_BUS)      cti_d = 3'b000;
        else if (len_d == 3'd0)    cti_d = 3'b000;
        else if (beat_d == len_d)  cti_d = 3'b111;
        else                       cti_d = 3'b010;
    end

    always_ff @(posedge clk_int or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            len_q       <= 3'd0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            beat_q      <= 3'd0;
            rty_q       <= '0;
            gap_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cti_q       <= 3'd0;
            status_q    <= 2'd0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            len_q       <= len_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            beat_q      <= beat_d;
            rty_q       <= rty_d;
            gap_q       <= gap_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cti_q       <= cti_d;
            status_q    <= status_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            cmd_ready_q <= (state_d == S_IDLE);
            wr_ready_q  <= (state_d == S_WDATA);
            rsp_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign wr_ready   = wr_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign busy       = busy_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign wb_cti_o   = cti_q;
    assign wb_bte_o   = 2'b00;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: behavioural Wishbone slave with wait/err/rty/silent modes plus write-data source.
module tb_wb_cmd_master;
    logic        clk_int = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [2:0]  cmd_len = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_last, rsp_valid, busy;
    logic [31:0] rd_data;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    wb_cmd_master dut (
        .clk_int(clk_int), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk_int = ~clk_int;

    int n_tests = 0, n_fail = 0;

    // Slave configuration and logs.
    int s_wait = 0, s_err_beat = -1, s_rty_left = 0, s_beat = 0, wcnt = 0;
    bit s_rty_all = 0, s_silent = 0, prev_err = 0;
    int n_log = 0, n_rd = 0, n_rsp = 0, n_stb = 0, cyc_n = 0;
    logic [31:0] log_adr [64], log_dat [64];
    logic [2:0]  log_cti [64];
    logic [3:0]  log_sel [64];
    logic        log_we [64];
    int          log_kind [64], log_cyc [64];
    logic [31:0] rd_log [16];
    logic        rd_last_log [16];
    logic [1:0]  last_status = '0;
    logic        err_next_cyc = 1'b1;
    logic [31:0] wq [8];
    int wr_n = 0, wr_idx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slave_cfg(input int wait_n, input int err_beat, input int rty_n,
                             input bit rty_all, input bit silent);
        s_wait = wait_n; s_err_beat = err_beat; s_rty_left = rty_n;
        s_rty_all = rty_all; s_silent = silent;
        s_beat = 0; wcnt = 0; n_log = 0; n_rd = 0; n_rsp = 0; n_stb = 0;
        err_next_cyc = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_int);
        rst = 1'b1; cmd_valid = 1'b0; wr_n = 0; wr_idx = 0;
        repeat (2) @(negedge clk_int);
        rst = 1'b0;
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [2:0] len,
                             input logic [3:0] sel);
        int n = 0;
        @(negedge clk_int);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = sel;
        while (!cmd_ready && n < 50) begin @(negedge clk_int); n++; end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk_int);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (n_rsp == 0 && n < budget) begin @(negedge clk_int); n++; end
        @(negedge clk_int);
        chk(tag, 32'(n_rsp), 32'd1);
    endtask

    // Bus slave, write-data source and output monitor, all sampled on the falling edge.
    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge clk_int);
            cyc_n++;
            if (prev_err) begin err_next_cyc = wb_cyc_o; prev_err = 0; end
            if (rd_valid && n_rd < 16) begin
                rd_log[n_rd] = rd_data; rd_last_log[n_rd] = rd_last; n_rd++;
            end
            if (rsp_valid) begin n_rsp++; last_status = rsp_status; end
            if (wr_valid) wr_idx++;
            if (wr_ready && wr_idx < wr_n) begin wr_valid = 1'b1; wr_data = wq[wr_idx]; end
            else wr_valid = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                n_stb++;
                if (wcnt < s_wait) wcnt++;
                else if (!s_silent) begin
                    wcnt = 0;
                    log_adr[n_log] = wb_adr_o; log_dat[n_log] = wb_dat_o; log_cti[n_log] = wb_cti_o;
                    log_sel[n_log] = wb_sel_o; log_we[n_log] = wb_we_o; log_cyc[n_log] = cyc_n;
                    if (s_rty_all || s_rty_left > 0) begin
                        wb_rty_i = 1'b1; log_kind[n_log] = 2;
                        if (s_rty_left > 0) s_rty_left--;
                    end else if (s_beat == s_err_beat) begin
                        wb_err_i = 1'b1; prev_err = 1; log_kind[n_log] = 1;
                    end else begin
                        wb_ack_i = 1'b1; wb_dat_i = 32'hD000_0000 ^ wb_adr_o;
                        log_kind[n_log] = 0; s_beat++;
                    end
                    if (n_log < 63) n_log++;
                end
            end else wcnt = 0;
        end
    end

    logic [2:0]  exp_cti [4];
    logic [31:0] exp_adr [3];

    initial begin
        // Reset state, checked while reset is held
        #1 rst = 1'b1;
        #2;
        chk("rst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        chk("rst_ready_busy", 32'({cmd_ready, wr_ready, busy}), 32'd0);
        chk("rst_rsp_rd", 32'({rsp_valid, rsp_status, rd_valid, rd_last}), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_cti_bte", 32'({wb_cti_o, wb_bte_o}), 32'd0);
        repeat (2) @(negedge clk_int);
        rst = 1'b0;

        // Single read, 2 wait states, unaligned address
        slave_cfg(2, -1, 0, 0, 0);
        issue_cmd(1'b0, 32'h0000_1003, 3'd0, 4'hF);
        chk("rd1_lat", 32'({wb_cyc_o, wb_stb_o}), 32'd3);
        chk("rd1_adr_early", wb_adr_o, 32'h0000_1000);
        wait_rsp("rd1_rsp", 50);
        chk("rd1_nlog", 32'(n_log), 32'd1);
        chk("rd1_adr", log_adr[0], 32'h0000_1000);
        chk("rd1_cti", 32'(log_cti[0]), 32'd0);
        chk("rd1_we", 32'(log_we[0]), 32'd0);
        chk("rd1_nrd", 32'(n_rd), 32'd1);
        chk("rd1_data", rd_log[0], 32'hD000_1000);
        chk("rd1_last", 32'(rd_last_log[0]), 32'd1);
        chk("rd1_status", 32'(last_status), 32'd0);

        // 4-beat write burst
        slave_cfg(0, -1, 0, 0, 0);
        wq[0] = 32'hAAAA_0001; wq[1] = 32'hBBBB_0002; wq[2] = 32'hCCCC_0003; wq[3] = 32'hDDDD_0004;
        wr_idx = 0; wr_n = 4;
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010; exp_cti[2] = 3'b010; exp_cti[3] = 3'b111;
        issue_cmd(1'b1, 32'h0000_2000, 3'd3, 4'hF);
        wait_rsp("wb4_rsp", 100);
        chk("wb4_nlog", 32'(n_log), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb4_adr%0d", i), log_adr[i], 32'h0000_2000 + 32'(4 * i));
            chk($sformatf("wb4_dat%0d", i), log_dat[i], wq[i]);
            chk($sformatf("wb4_cti%0d", i), 32'(log_cti[i]), 32'(exp_cti[i]));
            chk($sformatf("wb4_we_sel%0d", i), 32'({log_we[i], log_sel[i]}), 32'h1F);
        end
        chk("wb4_status", 32'(last_status), 32'd0);
        chk("wb4_nrd", 32'(n_rd), 32'd0);

        // 8-beat read terminated by err on beat 3
        slave_cfg(0, 2, 0, 0, 0);
        issue_cmd(1'b0, 32'h0000_3000, 3'd7, 4'hF);
        wait_rsp("err_rsp", 100);
        chk("err_nrd", 32'(n_rd), 32'd2);
        chk("err_rd1", rd_log[1], 32'hD000_3004);
        chk("err_rdlast", 32'({rd_last_log[0], rd_last_log[1]}), 32'd0);
        chk("err_kind", 32'(log_kind[2]), 32'd1);
        chk("err_cti0", 32'(log_cti[0]), 32'b010);
        chk("err_cyc_drop", 32'(err_next_cyc), 32'd0);
        chk("err_status", 32'(last_status), 32'd1);

        // Single write with two retries then ack
        slave_cfg(0, -1, 2, 0, 0);
        wq[0] = 32'h1234_5678; wr_idx = 0; wr_n = 1;
        issue_cmd(1'b1, 32'h0000_4000, 3'd0, 4'h3);
        wait_rsp("rty2_rsp", 100);
        chk("rty2_nlog", 32'(n_log), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rty2_adr%0d", i), log_adr[i], 32'h0000_4000);
            chk($sformatf("rty2_dat%0d", i), log_dat[i], 32'h1234_5678);
            chk($sformatf("rty2_cti%0d", i), 32'(log_cti[i]), 32'd0);
        end
        chk("rty2_gap1", 32'(log_cyc[1] - log_cyc[0] - 1), 32'd4);
        chk("rty2_gap2", 32'(log_cyc[2] - log_cyc[1] - 1), 32'd4);
        chk("rty2_kind", 32'(log_kind[2]), 32'd0);
        chk("rty2_status", 32'(last_status), 32'd0);

        // Retry forever: 16 attempts then exhausted
        slave_cfg(0, -1, 0, 1, 0);
        issue_cmd(1'b0, 32'h0000_5000, 3'd0, 4'hF);
        wait_rsp("rtyx_rsp", 300);
        chk("rtyx_attempts", 32'(n_log), 32'd16);
        chk("rtyx_adr15", log_adr[15], 32'h0000_5000);
        chk("rtyx_status", 32'(last_status), 32'd2);

        // Silent slave
        slave_cfg(0, -1, 0, 0, 1);
        issue_cmd(1'b0, 32'h0000_6000, 3'd0, 4'hF);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        wait_rsp("to_rsp", 400);
        chk("to_stb_cycles", 32'(n_stb), 32'd255);
        chk("to_status", 32'(last_status), 32'd3);
        chk("to_cyc", 32'(wb_cyc_o), 32'd0);
`else
        repeat (300) @(negedge clk_int);
        chk("to_busy", 32'({busy, wb_cyc_o, wb_stb_o}), 32'd7);
        chk("to_norsp", 32'(n_rsp), 32'd0);
        do_reset();
`endif

        // Reset in the middle of a write burst
        slave_cfg(0, -1, 0, 0, 0);
        wq[0] = 32'h7000_0001; wq[1] = 32'h7000_0002; wq[2] = 32'h7000_0003; wq[3] = 32'h7000_0004;
        wr_idx = 0; wr_n = 4;
        issue_cmd(1'b1, 32'h0000_7000, 3'd3, 4'hF);
        begin
            int n = 0;
            while (s_beat < 2 && n < 100) begin @(negedge clk_int); n++; end
        end
        chk("rstm_beats", 32'(s_beat), 32'd2);
        #2 rst = 1'b1; wr_n = 0;
        #1;
        chk("rstm_cyc_stb", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
        chk("rstm_ctrl", 32'({cmd_ready, wr_ready, busy, rsp_valid, rd_valid}), 32'd0);
        chk("rstm_adr", wb_adr_o, 32'd0);
        chk("rstm_dat", wb_dat_o, 32'd0);
        chk("rstm_sel_cti", 32'({wb_sel_o, wb_cti_o}), 32'd0);
        repeat (2) @(negedge clk_int);
        rst = 1'b0;
        repeat (3) @(negedge clk_int);
        chk("rstm_norsp", 32'(n_rsp), 32'd0);
        slave_cfg(0, -1, 0, 0, 0);
        issue_cmd(1'b0, 32'h0000_8000, 3'd0, 4'hF);
        wait_rsp("rstm_new_rsp", 50);
        chk("rstm_new_data", rd_log[0], 32'hD000_8000);
        chk("rstm_new_status", 32'(last_status), 32'd0);

        // 3-beat read burst wrapping through address zero
        slave_cfg(1, -1, 0, 0, 0);
        exp_adr[0] = 32'hFFFF_FFF8; exp_adr[1] = 32'hFFFF_FFFC; exp_adr[2] = 32'h0000_0000;
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010; exp_cti[2] = 3'b111;
        issue_cmd(1'b0, 32'hFFFF_FFF8, 3'd2, 4'hF);
        wait_rsp("wrap_rsp", 100);
        chk("wrap_nrd", 32'(n_rd), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_adr%0d", i), log_adr[i], exp_adr[i]);
            chk($sformatf("wrap_cti%0d", i), 32'(log_cti[i]), 32'(exp_cti[i]));
        end
        chk("wrap_rd0", rd_log[0], 32'h2FFF_FFF8);
        chk("wrap_rd2", rd_log[2], 32'hD000_0000);
        chk("wrap_last", 32'({rd_last_log[0], rd_last_log[1], rd_last_log[2]}), 32'b001);
        chk("wrap_status", 32'(last_status), 32'd0);
        chk("bte", 32'(wb_bte_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
